// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants for the fetch/decode pipeline register: exception codes,
// reset and handler entry addresses, and the NOP encoding.
package fd_pipe_reg_pkg;

  localparam logic [5:0]  exc_none  = 6'd0;
  localparam logic [5:0]  exc_adel  = 6'd4;
  localparam logic [5:0]  exc_ades  = 6'd5;
  localparam logic [5:0]  exc_sys   = 6'd8;
  localparam logic [5:0]  exc_ri    = 6'd10;
  localparam logic [5:0]  exc_ov    = 6'd12;

  localparam logic [31:0] pc_reset_addr   = 32'h0000_3000;
  localparam logic [31:0] pc_handler_addr = 32'h0000_4180;
  localparam logic [31:0] nop             = 32'h0000_0000;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field: async reset value, synchronous load of a constant
// (flush), hold (stall), otherwise capture d. Constant load beats hold.
module pipe_field_reg #(
  parameter int         W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_const,
  input  logic [W-1:0] const_val,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load_const) begin
      q <= const_val;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with stall, exception flush and ERET flush.
// Bubbles always carry an aligned PC so decode never flags a spurious AdEL.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = pc_reset_addr,
  parameter logic [31:0] PC_HANDLER = pc_handler_addr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_exc,
  input  logic        flush_eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc8_f,
  input  logic [5:0]  exccode_f,
  input  logic        bd_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc8_d,
  output logic [5:0]  exccode_d,
  output logic        bd_d,
  output logic        valid_d
);

  localparam logic [31:0] PC8_RESET   = PC_RESET + 32'd8;
  localparam logic [31:0] PC8_HANDLER = PC_HANDLER + 32'd8;

  logic        flush;
  logic [31:0] bubble_pc8;
  logic [31:0] instr_load;

  assign flush = flush_exc | flush_eret;

  // flush_exc outranks flush_eret when both arrive together
  assign bubble_pc8 = flush_exc ? PC8_HANDLER
                                : ((epc & 32'hFFFF_FFFC) + 32'd8);

  // A faulting fetch must not carry its (garbage) opcode into decode
  assign instr_load = (exccode_f == exc_none) ? instr_f : nop;

  pipe_field_reg #(.W(32), .RST_VAL(nop)) u_instr (
    .clk(clk), .rst(reset), .load_const(flush), .const_val(nop),
    .hold(stall), .d(instr_load), .q(instr_d)
  );

  pipe_field_reg #(.W(32), .RST_VAL(PC8_RESET)) u_pc8 (
    .clk(clk), .rst(reset), .load_const(flush), .const_val(bubble_pc8),
    .hold(stall), .d(pc8_f), .q(pc8_d)
  );

  pipe_field_reg #(.W(6), .RST_VAL(exc_none)) u_exccode (
    .clk(clk), .rst(reset), .load_const(flush), .const_val(exc_none),
    .hold(stall), .d(exccode_f), .q(exccode_d)
  );

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_bd (
    .clk(clk), .rst(reset), .load_const(flush), .const_val(1'b0),
    .hold(stall), .d(bd_f), .q(bd_d)
  );

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .rst(reset), .load_const(flush), .const_val(1'b0),
    .hold(stall), .d(1'b1), .q(valid_d)
  );

endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- Fetch/Decode pipeline register. Sits directly upstream of the decode-stage instruction exception checker.
- Captures the fetched instruction, PC+8, fetch exception code and delay-slot flag each cycle. Supplies them to decode.
- Handles stall (hold), exception/interrupt flush and ERET flush.
- Bubbles always carry an aligned, in-range PC, so the downstream address check never raises a spurious AdEL on a bubble.

Parameters:
- PC_RESET, 32'h0000_3000, first instruction address; bubbles after reset carry this PC.
- PC_HANDLER, 32'h0000_4180, exception entry address; bubbles after an exception flush carry this PC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; hold all state.
- flush_exc  in  1  exception/interrupt taken this cycle (from CP0).
- flush_eret  in  1  ERET committing this cycle.
- epc  in  32  EPC value from CP0; used on flush_eret.
- instr_f  in  32  instruction read from IM.
- pc8_f  in  32  fetch PC + 8.
- exccode_f  in  6  fetch-side exception code; 0 = none, exc_Adel = misaligned/out-of-range fetch.
- bd_f  in  1  fetched instruction is a branch delay slot (branch/jump currently in decode).
- instr_d  out  32  instruction to decode.
- pc8_d  out  32  PC + 8 to decode.
- exccode_d  out  6  carried exception code.
- bd_d  out  1  delay-slot flag to decode.
- valid_d  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- All outputs are flops, updated on the rising clk edge. Latency F->D is 1 cycle.
- Reset is asynchronous and active-high, effective immediately, even mid-stall or mid-flush. Reset values:
  - instr_d = 0 (nop), pc8_d = PC_RESET+8, exccode_d = 0, bd_d = 0, valid_d = 0.
- Per-edge priority, highest first:
  1. flush_exc: load a bubble with instr_d = 0, pc8_d = PC_HANDLER+8, exccode_d = 0, bd_d = 0, valid_d = 0.
  2. flush_eret: load a bubble with pc8_d = {epc[31:2],2'b00}+8; other fields as a flush_exc bubble.
  3. stall: hold every output unchanged.
  4. Otherwise load normally:
     - pc8_d = pc8_f, exccode_d = exccode_f, bd_d = bd_f, valid_d = 1.
     - instr_d = instr_f if exccode_f == 0, else 32'h0. A faulting fetch must never decode real opcodes; its PC and code survive to reach CP0.
- Simultaneous events:
  - flush_exc with flush_eret: flush_exc wins.
  - Any flush with stall: the flush wins; the bubble is loaded regardless of stall.
- Stall for N cycles: outputs stay constant for all N cycles. On the first non-stall edge the register loads the F values present at that edge.
- Arithmetic: the +8 is 32-bit unsigned, wraps modulo 2^32, no overflow flag.
- bd_d is a pure pass-through of bd_f on load. It is cleared only by flush or reset, never by stall.
- Only one internal state exists: valid_d together with the data flops. No FSM beyond this priority mux.

Decomposition:
- Shared header (existing heads.v):
  - exc_Adel and the other exception-code macros.
  - PC_RESET and PC_HANDLER as defines, referenced as parameter defaults.
  - NOP constant (32'h0).
- Sub-module: pipe_field_reg (width-parameterised flop with async reset value, hold, and synchronous load-constant). Instantiate one per field. No further hierarchy.

Test Plan:
- Reset: assert reset mid-cycle with instr_f = 32'h2408_0001 -> outputs change immediately to instr_d = 0, pc8_d = 32'h3008, valid_d = 0, without waiting for a clock edge.
- Normal load: instr_f = 32'h2408_0001, pc8_f = 32'h3010, exccode_f = 0, bd_f = 1 -> next edge instr_d = 32'h2408_0001, pc8_d = 32'h3010, bd_d = 1, valid_d = 1.
- Fetch fault: pc8_f = 32'h3012, exccode_f = exc_Adel, instr_f = 32'hFFFF_FFFF -> instr_d = 0, pc8_d = 32'h3012, exccode_d = exc_Adel, valid_d = 1.
- Stall: load 32'h0000_0020, then stall 3 cycles while instr_f changes -> instr_d stays 32'h0000_0020; the 4th edge loads the current instr_f.
- Flush during stall: stall = 1 and flush_exc = 1 on the same edge -> instr_d = 0, pc8_d = 32'h4188, bd_d = 0, valid_d = 0.
- ERET, and flush_exc + flush_eret together:
  - flush_eret alone with epc = 32'h0000_3104 -> pc8_d = 32'h310C, valid_d = 0.
  - flush_exc and flush_eret on the same edge -> pc8_d = 32'h4188.
